// File: rtl/cache_types.sv
// Shared types and sizing constants for the cacheline adaptor.
package cache_types;

  localparam int CLA_BEATS   = 4;
  localparam int CLA_S_BURST = 64;
  localparam int CLA_S_LINE  = 256;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    DONE = 2'd3
  } cla_state_t;

endpackage

// File: rtl/cacheline_adaptor_if.sv
// Cache-side line port and memory-side burst port of the cacheline adaptor.
// The slave modport is the adaptor's view; master is the environment's view.
interface cacheline_adaptor_if;
  import cache_types::*;

  // cache side
  logic [CLA_S_LINE-1:0]  line_i;
  logic [CLA_S_LINE-1:0]  line_o;
  logic [31:0]            address_i;
  logic                   read_i;
  logic                   write_i;
  logic                   resp_o;
  // memory side
  logic [CLA_S_BURST-1:0] burst_i;
  logic [CLA_S_BURST-1:0] burst_o;
  logic [31:0]            address_o;
  logic                   read_o;
  logic                   write_o;
  logic                   resp_i;

  modport slave (
    input  line_i, address_i, read_i, write_i, burst_i, resp_i,
    output line_o, resp_o, burst_o, address_o, read_o, write_o
  );

  modport master (
    output line_i, address_i, read_i, write_i, burst_i, resp_i,
    input  line_o, resp_o, burst_o, address_o, read_o, write_o
  );

endinterface

// File: rtl/cacheline_adaptor.sv
// Cacheline adaptor: turns one 256-bit line read/write into a 4-beat 64-bit
// burst on the memory port and returns a one-cycle completion to the cache.
// Optional: define CLA_PROTOCOL_CHECK_EN to add the sticky err_o output.
module cacheline_adaptor
  import cache_types::*;
#(
  parameter int BEATS   = CLA_BEATS,
  parameter int S_BURST = CLA_S_BURST,
  parameter int S_LINE  = CLA_S_LINE
) (
  input  logic                clk,
  input  logic                rst,
  cacheline_adaptor_if.slave  bus
`ifdef CLA_PROTOCOL_CHECK_EN
  ,
  output logic                err_o
`endif
);

  localparam int BW = $clog2(BEATS);
  // Byte offset of a line; burst addresses are line aligned.
  localparam logic [31:0] LINE_MASK = ~32'(S_LINE / 8 - 1);

  cla_state_t         state_reg, state_next;
  logic [BW-1:0]      beat_reg, beat_next;
  logic [31:0]        addr_reg;
  logic [S_BURST-1:0] wr_line_reg [BEATS];
  logic [S_BURST-1:0] fill_reg    [BEATS];

  // State register, beat counter, latched request and fill beats.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_reg <= IDLE;
      beat_reg  <= '0;
      addr_reg  <= '0;
      for (int i = 0; i < BEATS; i++) begin
        wr_line_reg[i] <= '0;
        fill_reg[i]    <= '0;
      end
    end else begin
      state_reg <= state_next;
      beat_reg  <= beat_next;
      if (state_reg == IDLE && (bus.write_i || bus.read_i)) begin
        addr_reg <= bus.address_i & LINE_MASK;
      end
      if (state_reg == IDLE && bus.write_i) begin
        for (int i = 0; i < BEATS; i++) begin
          wr_line_reg[i] <= bus.line_i[i*S_BURST +: S_BURST];
        end
      end
      if (state_reg == RD && bus.resp_i) begin
        for (int i = 0; i < BEATS; i++) begin
          if (beat_reg == BW'(i)) begin
            fill_reg[i] <= bus.burst_i;
          end
        end
      end
    end
  end

  // Next state and beat count; a beat only advances on resp_i.
  always_comb begin
    state_next = state_reg;
    beat_next  = beat_reg;
    case (state_reg)
      IDLE: begin
        if (bus.write_i) begin
          state_next = WR;
        end else if (bus.read_i) begin
          state_next = RD;
        end
      end
      RD, WR: begin
        if (bus.resp_i) begin
          beat_next = beat_reg + 1'b1;
          if (beat_reg == BW'(BEATS - 1)) begin
            state_next = DONE;
          end
        end
      end
      DONE: begin
        state_next = IDLE;
        beat_next  = '0;
      end
      default: begin
        state_next = IDLE;
        beat_next  = '0;
      end
    endcase
  end

  // Output decode; burst_o shows the current write beat only while writing.
  always_comb begin
    bus.read_o    = (state_reg == RD);
    bus.write_o   = (state_reg == WR);
    bus.resp_o    = (state_reg == DONE);
    bus.address_o = addr_reg;
    bus.burst_o   = '0;
    if (state_reg == WR) begin
      bus.burst_o = wr_line_reg[beat_reg];
    end
    bus.line_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      bus.line_o[i*S_BURST +: S_BURST] = fill_reg[i];
    end
  end

`ifdef CLA_PROTOCOL_CHECK_EN
  logic err_reg;

  // Sticky protocol violation flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst) begin
      err_reg <= 1'b0;
    end else if (((state_reg == IDLE || state_reg == DONE) && bus.resp_i) ||
                 (state_reg == IDLE && bus.read_i && bus.write_i) ||
                 (state_reg == RD && !bus.read_i) ||
                 (state_reg == WR && !bus.write_i)) begin
      err_reg <= 1'b1;
    end
  end

  assign err_o = err_reg;
`endif

endmodule

// File: tb/tb_cacheline_adaptor.sv
// Scoreboard bench for cacheline_adaptor: directed line requests against a
// small burst memory model; monitors check beats and completions.
module tb_cacheline_adaptor;
  import cache_types::*;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  cacheline_adaptor_if bus ();
`ifdef CLA_PROTOCOL_CHECK_EN
  logic err_o;
`endif

  cacheline_adaptor dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus)
`ifdef CLA_PROTOCOL_CHECK_EN
    ,
    .err_o(err_o)
`endif
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;

  typedef struct {
    logic         wr;
    logic [31:0]  addr;
    logic [255:0] line;
    int           req_cyc;
    logic         chk_lat;
  } txn_t;

  txn_t sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(string name, logic [255:0] act, logic [255:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic fail_now(string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  // ---------------- memory model ----------------
  logic [63:0] mem [4096];
  int   mem_beat = 0;
  logic wait_mode = 1'b0;
  logic phase = 1'b0;
  logic spur = 1'b0;

  function automatic logic [11:0] mem_idx();
    logic [31:0] a;
    a = bus.address_o + 32'(mem_beat * 8);
    return a[14:3];
  endfunction

  always @(posedge clk) begin
    if (!rst) begin
      mem_beat <= 0;
    end else if (bus.resp_i && (bus.read_o || bus.write_o)) begin
      if (bus.write_o) mem[mem_idx()] <= bus.burst_o;
      mem_beat <= (mem_beat + 1) % 4;
    end
  end

  always begin
    @(posedge clk);
    #1;
    phase = ~phase;
    if (bus.read_o || bus.write_o) bus.resp_i = wait_mode ? phase : 1'b1;
    else bus.resp_i = spur;
    bus.burst_i = bus.read_o ? mem[mem_idx()] : 64'h0;
  end

  // ---------------- monitors ----------------
  always @(negedge clk) begin
    if (rst && bus.resp_i && (bus.read_o || bus.write_o)) begin
      if (sb.size() == 0) begin
        fail_now("beat_without_request");
      end else begin
        logic [255:0] l;
        logic [63:0]  b;
        l = sb[0].line;
        b = l[mem_beat*64 +: 64];
        check("beat_dir_write", 256'(bus.write_o), 256'(sb[0].wr));
        check("address_o", 256'(bus.address_o), 256'(sb[0].addr));
        if (sb[0].wr) check("burst_o", 256'(bus.burst_o), 256'(b));
      end
    end
  end

  always @(negedge clk) begin
    if (bus.resp_o) begin
      if (sb.size() == 0) begin
        fail_now("unexpected_resp_o");
      end else begin
        txn_t t;
        t = sb.pop_front();
        $display("txn %s addr=%h done at cycle %0d", t.wr ? "WR" : "RD", t.addr, cyc);
        if (!t.wr) check("line_o", bus.line_o, t.line);
        if (t.chk_lat) check("latency", 256'(cyc - t.req_cyc), 256'(5));
        check("rw_low_in_done", 256'({bus.read_o, bus.write_o}), 256'(0));
      end
    end
  end

  // ---------------- driver ----------------
  task automatic start_req(logic wr, logic rd, logic [31:0] addr, logic [255:0] lin,
                           logic exp_wr, logic [31:0] exp_addr, logic [255:0] exp_line,
                           logic lat);
    txn_t t;
    bus.write_i   = wr;
    bus.read_i    = rd;
    bus.address_i = addr;
    bus.line_i    = lin;
    t.wr      = exp_wr;
    t.addr    = exp_addr;
    t.line    = exp_line;
    t.req_cyc = cyc;
    t.chk_lat = lat;
    sb.push_back(t);
  endtask

  task automatic wait_resp(string name);
    int k;
    k = 0;
    while (!bus.resp_o && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!bus.resp_o) fail_now({name, "_timeout"});
    bus.read_i  = 1'b0;
    bus.write_i = 1'b0;
  endtask

  localparam logic [255:0] L1 = {64'h4444444444444444, 64'h3333333333333333,
                                 64'h2222222222222222, 64'h1111111111111111};
  localparam logic [255:0] L2 = {64'hAAAAAAAAAAAAAAAA, 64'hFEDCBA9876543210,
                                 64'h0F0F0F0F0F0F0F0F, 64'h0123456789ABCDEF};
  localparam logic [255:0] L3 = {64'h3000000000000033, 64'h3000000000000022,
                                 64'h3000000000000011, 64'h3000000000000000};
  localparam logic [255:0] L4 = {64'h8888888888888888, 64'h7777777777777777,
                                 64'h6666666666666666, 64'h5555555555555555};
  localparam logic [255:0] L6 = {64'hDEADBEEF00000004, 64'hDEADBEEF00000003,
                                 64'hDEADBEEF00000002, 64'hDEADBEEF00000001};

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.line_i    = '0;
    bus.address_i = '0;
    bus.read_i    = 1'b0;
    bus.write_i   = 1'b0;
    bus.burst_i   = '0;
    bus.resp_i    = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = 64'h0;
    mem[12'h244] = 64'h1111111111111111;  // 0x1220
    mem[12'h245] = 64'h2222222222222222;
    mem[12'h246] = 64'h3333333333333333;
    mem[12'h247] = 64'h4444444444444444;
    mem[12'h800] = 64'h5555555555555555;  // 0x4000
    mem[12'h801] = 64'h6666666666666666;
    mem[12'h802] = 64'h7777777777777777;
    mem[12'h803] = 64'h8888888888888888;

    // reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_resp_read_write", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
    check("reset_address_o", 256'(bus.address_o), 256'(0));
    check("reset_burst_o", 256'(bus.burst_o), 256'(0));
    check("reset_line_o", bus.line_o, 256'(0));
`ifdef CLA_PROTOCOL_CHECK_EN
    check("reset_err_o", 256'(err_o), 256'(0));
`endif
    rst = 1'b1;
    @(negedge clk);

    // read, zero wait
    start_req(1'b0, 1'b1, 32'h0000_1234, '0, 1'b0, 32'h0000_1220, L1, 1'b1);
    wait_resp("read_zero_wait");
    @(negedge clk);
    check("resp_one_cycle", 256'(bus.resp_o), 256'(0));
`ifdef CLA_PROTOCOL_CHECK_EN
    check("err_clean_read", 256'(err_o), 256'(0));
`endif

    // write with wait states
    wait_mode = 1'b1;
    start_req(1'b1, 1'b0, 32'h0000_2047, L2, 1'b1, 32'h0000_2040, L2, 1'b0);
    wait_resp("write_wait_states");
    wait_mode = 1'b0;
    @(negedge clk);
    check("line_o_hold", bus.line_o, L1);

    // simultaneous read and write: write wins
    start_req(1'b1, 1'b1, 32'h0000_3010, L3, 1'b1, 32'h0000_3000, L3, 1'b0);
    wait_resp("both_requests");
`ifdef CLA_PROTOCOL_CHECK_EN
    check("err_both_requests", 256'(err_o), 256'(1));
`endif
    @(negedge clk);
`ifdef CLA_PROTOCOL_CHECK_EN
    check("err_sticky", 256'(err_o), 256'(1));
`endif

    // reset after beat 2 of a read
    start_req(1'b0, 1'b1, 32'h0000_4000, '0, 1'b0, 32'h0000_4000, L4, 1'b0);
    begin
      int k;
      k = 0;
      while (mem_beat != 2 && k < 50) begin
        @(negedge clk);
        k++;
      end
      if (mem_beat != 2) fail_now("abort_beat2_timeout");
    end
    rst = 1'b0;
    bus.read_i = 1'b0;
    sb.delete();
    @(negedge clk);
    check("abort_read_o", 256'(bus.read_o), 256'(0));
    check("abort_line_o", bus.line_o, 256'(0));
    check("abort_resp_o", 256'(bus.resp_o), 256'(0));
    rst = 1'b1;
`ifdef CLA_PROTOCOL_CHECK_EN
    check("err_cleared_by_reset", 256'(err_o), 256'(0));
`endif
    @(negedge clk);
    start_req(1'b0, 1'b1, 32'h0000_4008, '0, 1'b0, 32'h0000_4000, L4, 1'b1);
    wait_resp("read_after_abort");
    @(negedge clk);

    // spurious resp_i in IDLE
    spur = 1'b1;
    @(negedge clk);
    spur = 1'b0;
    repeat (3) @(negedge clk);
    check("spurious_idle_quiet", 256'({bus.resp_o, bus.read_o, bus.write_o}), 256'(0));
`ifdef CLA_PROTOCOL_CHECK_EN
    check("err_spurious_resp", 256'(err_o), 256'(1));
`endif

    // write then read back-to-back, same address
    start_req(1'b1, 1'b0, 32'h0000_5000, L6, 1'b1, 32'h0000_5000, L6, 1'b0);
    wait_resp("b2b_write");
    start_req(1'b0, 1'b1, 32'h0000_5000, '0, 1'b0, 32'h0000_5000, L6, 1'b0);
    @(negedge clk);
    check("b2b_idle_gap", 256'(bus.read_o), 256'(0));
    @(negedge clk);
    check("b2b_read_issued", 256'(bus.read_o), 256'(1));
    wait_resp("b2b_read");

    repeat (3) @(negedge clk);
    if (sb.size() != 0) fail_now("scoreboard_not_empty");
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
